bingo_draw_ctrl: RTL and testbench
==================================

BINGO_DRAW_CTRL -- requirements
Module: bingo_draw_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_NUM, default 90, meaning the highest legal ball number (legal range 1..99).
REQ-002 The block SHALL have port clk, input, 1 bit, system clock.
REQ-003 The block SHALL have port rstn, input, 1 bit, reset: synchronous, active-low.
REQ-004 The block SHALL have port start_game, input, 1 bit, level; game armed when high.
REQ-005 The block SHALL have port new_game, input, 1 bit, pulse; abort the current game and clear all history.
REQ-006 The block SHALL have port key_valid, input, 1 bit, one-cycle pulse per debounced key press.
REQ-007 The block SHALL have port key_code, input, 4 bits, key code: 0-9 digit, 10 CLEAR, 11 ENTER, 12-15 ignored.
REQ-008 The block SHALL have port num_valid, output, 1 bit, one-cycle pulse when a number is accepted.
REQ-009 The block SHALL have port number, output, 7 bits, last accepted number, binary.
REQ-010 The block SHALL have port range_err, output, 1 bit, one-cycle pulse when an entry is 0 or above MAX_NUM.
REQ-011 The block SHALL have port dup_err, output, 1 bit, one-cycle pulse when an entry was already drawn.
REQ-012 The block SHALL have port draw_count, output, 7 bits, count of accepted numbers this game.
REQ-013 The block SHALL have port state, output, 3 bits, current FSM state encoding.
REQ-014 The block SHALL have port game_over, output, 1 bit, level; high while in DONE.

Function
REQ-015 FSM states and encodings SHALL be: IDLE=0, D1=1, D2=2, COMMIT=3, DONE=4.
REQ-016 IDLE: start_game high SHALL move to D1 on the next edge; key_valid SHALL be ignored.
REQ-017 D1: digit d SHALL set acc=d and move to D2; CLEAR SHALL keep D1 with acc=0; ENTER and codes 12-15 SHALL be ignored.
REQ-018 D2: digit d SHALL set acc=acc*10+d (7-bit result, max 99) and move to COMMIT; ENTER SHALL move to COMMIT with acc unchanged; CLEAR SHALL set acc=0 and move to D1.
REQ-019 COMMIT SHALL last exactly one cycle, and key_valid during COMMIT SHALL be dropped.
REQ-020 COMMIT check order: if acc==0 or acc>MAX_NUM then range_err; else if already drawn then dup_err; else num_valid. Exactly one of the three pulses SHALL fire.
REQ-021 On num_valid: number<=acc, draw_count increments, acc's bitmap bit sets; all three register updates take effect at the same edge as the pulse.
REQ-022 Latency: the key_valid that causes COMMIT is at edge N; the result pulse SHALL be high in cycle N+1 to N+2 (registered, one cycle).
REQ-023 After COMMIT, the FSM SHALL go to DONE if draw_count (post-update) equals MAX_NUM, else to D1 with acc=0.
REQ-024 DONE: game_over=1 and all keys ignored; the FSM SHALL leave DONE only via new_game or reset.
REQ-025 new_game SHALL have priority over every key event in every state and SHALL clear acc, the bitmap, draw_count and number, then enter IDLE next cycle.
REQ-026 start_game falling while in D1/D2 SHALL NOT abort the game; only new_game or reset aborts.
REQ-027 draw_count SHALL NOT exceed MAX_NUM; no wrap-around is possible because DONE blocks further commits.

Reset
REQ-028 rstn low at a clk edge SHALL force IDLE, acc=0, number=0, draw_count=0, bitmap all zero, num_valid=range_err=dup_err=game_over=0, overriding any in-flight COMMIT.

Configuration
REQ-029 Macro DUP_CHECK_EN defined: SHALL implement a MAX_NUM-bit drawn bitmap and dup_err per REQ-020.
REQ-030 DUP_CHECK_EN undefined: SHALL omit the bitmap, tie dup_err to 0, and accept repeats, with each repeat counted in draw_count.

Verification
REQ-031 start_game=1, keys 4,2 -> num_valid pulse, number=42, draw_count=1, state back to D1.
REQ-032 Keys 7,ENTER -> number=7; keys 9,5 (95>90) -> range_err, draw_count unchanged; keys 0,ENTER -> range_err.
REQ-033 With DUP_CHECK_EN: keys 4,2 twice -> second entry gives dup_err, draw_count=1; without the macro -> num_valid, draw_count=2.
REQ-034 Keys 3,CLEAR,5,ENTER -> number=5; key pressed during COMMIT cycle -> dropped, state D1.
REQ-035 MAX_NUM=3: enter 1,2,3 -> game_over=1 after third commit, further keys ignored; new_game -> IDLE, draw_count=0.
REQ-036 rstn low during the COMMIT cycle -> no result pulse, all outputs zero, state IDLE.

Source files
------------

// File: rtl/bingo_draw_ctrl.sv
// Bingo draw controller: keypad entry, range/duplicate checks, draw count.
// Optional DUP_CHECK_EN adds a drawn-number bitmap and dup_err.
module bingo_draw_ctrl #(
  parameter int MAX_NUM = 90
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start_game,
  input  logic       new_game,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       num_valid,
  output logic [6:0] number,
  output logic       range_err,
  output logic       dup_err,
  output logic [6:0] draw_count,
  output logic [2:0] state,
  output logic       game_over
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D1     = 3'd1,
    D2     = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t     cur, nxt;
  logic [6:0] acc, acc_nxt;
  logic [6:0] acc_x10;
  logic [6:0] cnt_inc;
  logic       is_digit, is_clear, is_enter;
  logic       in_range, hit, accept;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_clear = key_valid && (key_code == 4'd10);
  assign is_enter = key_valid && (key_code == 4'd11);

  assign acc_x10  = (acc << 3) + (acc << 1);
  assign in_range = (acc != 7'd0) && (acc <= 7'(MAX_NUM));
  assign accept   = (cur == COMMIT) && in_range && !hit;
  assign cnt_inc  = draw_count + 7'd1;

  assign state     = cur;
  assign game_over = (cur == DONE);

  always_comb begin
    nxt     = cur;
    acc_nxt = acc;
    if (new_game) begin
      nxt     = IDLE;
      acc_nxt = 7'd0;
    end else begin
      case (cur)
        IDLE: begin
          acc_nxt = 7'd0;
          if (start_game) nxt = D1;
        end
        D1: begin
          unique case (1'b1)
            is_digit: begin
              acc_nxt = {3'b000, key_code};
              nxt     = D2;
            end
            is_clear: acc_nxt = 7'd0;
            default: ;
          endcase
        end
        D2: begin
          unique case (1'b1)
            is_digit: begin
              acc_nxt = acc_x10 + {3'b000, key_code};
              nxt     = COMMIT;
            end
            is_enter: nxt = COMMIT;
            is_clear: begin
              acc_nxt = 7'd0;
              nxt     = D1;
            end
            default: ;
          endcase
        end
        COMMIT: begin
          // keys arriving now are dropped; acc restarts for next entry
          acc_nxt = 7'd0;
          if (accept && (cnt_inc == 7'(MAX_NUM))) nxt = DONE;
          else nxt = D1;
        end
        DONE:    ;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cur        <= IDLE;
      acc        <= 7'd0;
      number     <= 7'd0;
      draw_count <= 7'd0;
      num_valid  <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      cur       <= nxt;
      acc       <= acc_nxt;
      num_valid <= 1'b0;
      range_err <= 1'b0;
      if (new_game) begin
        number     <= 7'd0;
        draw_count <= 7'd0;
      end else if (cur == COMMIT) begin
        range_err <= !in_range;
        if (accept) begin
          num_valid  <= 1'b1;
          number     <= acc;
          draw_count <= cnt_inc;
        end
      end
    end
  end

`ifdef DUP_CHECK_EN
  logic [MAX_NUM-1:0] drawn;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < MAX_NUM; i++)
      if (drawn[i] && (acc == 7'(i + 1))) hit = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      drawn   <= '0;
      dup_err <= 1'b0;
    end else begin
      dup_err <= 1'b0;
      if (new_game) begin
        drawn <= '0;
      end else if (cur == COMMIT) begin
        dup_err <= in_range && hit;
        if (accept)
          for (int i = 0; i < MAX_NUM; i++)
            if (acc == 7'(i + 1)) drawn[i] <= 1'b1;
      end
    end
  end
`else
  assign hit     = 1'b0;
  assign dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_bingo_draw_ctrl.sv
// Bench for bingo_draw_ctrl: scoreboard of result pulses for MAX_NUM=90,
// inline checks of a MAX_NUM=3 instance for game-over behaviour.
module tb_bingo_draw_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] sg = '0;
  logic [1:0] ng = '0;
  logic [1:0] kv = '0;
  logic [3:0] kc [2];

  logic       nv0, re0, de0, go0;
  logic [6:0] num0, cnt0;
  logic [2:0] st0;
  logic       nv1, re1, de1, go1;
  logic [6:0] num1, cnt1;
  logic [2:0] st1;

  bingo_draw_ctrl #(.MAX_NUM(90)) u0 (
    .clk(clk), .rstn(rstn),
    .start_game(sg[0]), .new_game(ng[0]),
    .key_valid(kv[0]), .key_code(kc[0]),
    .num_valid(nv0), .number(num0),
    .range_err(re0), .dup_err(de0),
    .draw_count(cnt0), .state(st0),
    .game_over(go0)
  );

  bingo_draw_ctrl #(.MAX_NUM(3)) u1 (
    .clk(clk), .rstn(rstn),
    .start_game(sg[1]), .new_game(ng[1]),
    .key_valid(kv[1]), .key_code(kc[1]),
    .num_valid(nv1), .number(num1),
    .range_err(re1), .dup_err(de1),
    .draw_count(cnt1), .state(st1),
    .game_over(go1)
  );

  typedef struct {
    logic [2:0] kind;
    logic [6:0] num;
    logic [6:0] cnt;
  } exp_t;

  localparam logic [2:0] K_NV = 3'b100;
  localparam logic [2:0] K_RE = 3'b010;
  localparam logic [2:0] K_DE = 3'b001;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_cnt = 0;

  always @(negedge clk) begin
    if (nv0 || re0 || de0) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse got=%b",
                 {nv0, re0, de0});
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({nv0, re0, de0} !== e.kind ||
            (e.kind == K_NV && num0 !== e.num) ||
            cnt0 !== e.cnt) begin
          fails++;
          $display("FAIL result got=%b/%0d/%0d exp=%b/%0d/%0d",
                   {nv0, re0, de0}, num0, cnt0,
                   e.kind, e.num, e.cnt);
        end
      end
    end
  end

  task automatic drive(input int s, input logic v,
                       input logic [3:0] c);
    kv[s] = v;
    kc[s] = c;
  endtask

  // two keys from D1, optional key during COMMIT;
  // returns at the negedge where the result pulse shows
  task automatic entry(input int s,
                       input logic [3:0] a,
                       input logic [3:0] b,
                       input logic drop,
                       input logic [2:0] k,
                       input logic [6:0] n,
                       input logic [6:0] c);
    if (s == 0) q.push_back('{k, n, c});
    @(negedge clk) drive(s, 1'b1, a);
    @(negedge clk) drive(s, 1'b1, b);
    @(negedge clk) drive(s, drop, 4'd5);
    @(negedge clk) drive(s, 1'b0, 4'd0);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({st0, nv0, re0, de0, go0} !== 7'd0 ||
        num0 !== 7'd0 || cnt0 !== 7'd0) begin
      fails++;
      $display("FAIL reset st=%0d num=%0d cnt=%0d req 0",
               st0, num0, cnt0);
    end
    rstn = 1'b1;
    @(negedge clk) drive(0, 1'b1, 4'd4);
    @(negedge clk) drive(0, 1'b0, 4'd0);
    tests++;
    if (st0 !== 3'd0) begin
      fails++;
      $display("FAIL idle_keys st=%0d req 0", st0);
    end
  endtask

  task automatic test_basic;
    sg[0] = 1'b1;
    @(negedge clk);
    tests++;
    if (st0 !== 3'd1) begin
      fails++;
      $display("FAIL start st=%0d req 1", st0);
    end
    exp_cnt = 1;
    entry(0, 4'd4, 4'd2, 1'b0, K_NV, 7'd42, 7'd1);
    tests++;
    if (st0 !== 3'd1 || num0 !== 7'd42 || cnt0 !== 7'd1) begin
      fails++;
      $display("FAIL basic st=%0d num=%0d cnt=%0d req 1/42/1",
               st0, num0, cnt0);
    end
  endtask

  task automatic test_range;
    exp_cnt++;
    entry(0, 4'd7, 4'd11, 1'b0, K_NV, 7'd7, 7'(exp_cnt));
    entry(0, 4'd9, 4'd5, 1'b0, K_RE, 7'd0, 7'(exp_cnt));
    tests++;
    if (num0 !== 7'd7) begin
      fails++;
      $display("FAIL range_keeps_num num=%0d req 7", num0);
    end
    entry(0, 4'd0, 4'd11, 1'b0, K_RE, 7'd0, 7'(exp_cnt));
    entry(0, 4'd9, 4'd1, 1'b0, K_RE, 7'd0, 7'(exp_cnt));
    exp_cnt++;
    entry(0, 4'd9, 4'd0, 1'b0, K_NV, 7'd90, 7'(exp_cnt));
    exp_cnt++;
    entry(0, 4'd1, 4'd11, 1'b0, K_NV, 7'd1, 7'(exp_cnt));
    tests++;
    if (cnt0 !== 7'd4) begin
      fails++;
      $display("FAIL range_count cnt=%0d req 4", cnt0);
    end
  endtask

  task automatic test_dup;
`ifdef DUP_CHECK_EN
    entry(0, 4'd4, 4'd2, 1'b0, K_DE, 7'd0, 7'(exp_cnt));
`else
    exp_cnt++;
    entry(0, 4'd4, 4'd2, 1'b0, K_NV, 7'd42, 7'(exp_cnt));
`endif
    tests++;
    if (cnt0 !== 7'(exp_cnt)) begin
      fails++;
      $display("FAIL dup_count cnt=%0d req %0d", cnt0, exp_cnt);
    end
  endtask

  task automatic test_clear;
    @(negedge clk) drive(0, 1'b1, 4'd11);
    @(negedge clk) drive(0, 1'b0, 4'd0);
    tests++;
    if (st0 !== 3'd1) begin
      fails++;
      $display("FAIL d1_enter st=%0d req 1", st0);
    end
    exp_cnt++;
    q.push_back('{K_NV, 7'd5, 7'(exp_cnt)});
    @(negedge clk) drive(0, 1'b1, 4'd3);
    @(negedge clk) drive(0, 1'b1, 4'd10);
    @(negedge clk) drive(0, 1'b1, 4'd5);
    tests++;
    if (st0 !== 3'd1) begin
      fails++;
      $display("FAIL d2_clear st=%0d req 1", st0);
    end
    @(negedge clk) drive(0, 1'b1, 4'd11);
    @(negedge clk) drive(0, 1'b0, 4'd0);
    tests++;
    if (st0 !== 3'd3) begin
      fails++;
      $display("FAIL commit_state st=%0d req 3", st0);
    end
    @(negedge clk);
    tests++;
    if (st0 !== 3'd1 || num0 !== 7'd5) begin
      fails++;
      $display("FAIL clear st=%0d num=%0d req 1/5", st0, num0);
    end
  endtask

  task automatic test_commit_drop;
    exp_cnt++;
    entry(0, 4'd6, 4'd11, 1'b1, K_NV, 7'd6, 7'(exp_cnt));
    tests++;
    if (st0 !== 3'd1) begin
      fails++;
      $display("FAIL commit_drop st=%0d req 1", st0);
    end
  endtask

  task automatic test_start_fall;
    @(negedge clk) drive(0, 1'b1, 4'd8);
    @(negedge clk) drive(0, 1'b0, 4'd0);
    sg[0] = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (st0 !== 3'd2) begin
      fails++;
      $display("FAIL start_fall st=%0d req 2", st0);
    end
    exp_cnt++;
    q.push_back('{K_NV, 7'd8, 7'(exp_cnt)});
    @(negedge clk) drive(0, 1'b1, 4'd11);
    @(negedge clk) drive(0, 1'b0, 4'd0);
    @(negedge clk);
    tests++;
    if (st0 !== 3'd1 || num0 !== 7'd8) begin
      fails++;
      $display("FAIL start_fall_commit st=%0d num=%0d req 1/8",
               st0, num0);
    end
    sg[0] = 1'b1;
  endtask

  task automatic test_new_game;
    @(negedge clk) drive(0, 1'b1, 4'd3);
    @(negedge clk) drive(0, 1'b1, 4'd4);
    ng[0] = 1'b1;
    @(negedge clk) drive(0, 1'b0, 4'd0);
    ng[0] = 1'b0;
    tests++;
    if (st0 !== 3'd0 || cnt0 !== 7'd0 || num0 !== 7'd0) begin
      fails++;
      $display("FAIL new_game st=%0d cnt=%0d num=%0d req 0",
               st0, cnt0, num0);
    end
    @(negedge clk);
    tests++;
    if (st0 !== 3'd1) begin
      fails++;
      $display("FAIL new_game_restart st=%0d req 1", st0);
    end
    exp_cnt = 1;
    entry(0, 4'd4, 4'd2, 1'b0, K_NV, 7'd42, 7'd1);
  endtask

  task automatic test_reset_commit;
    @(negedge clk) drive(0, 1'b1, 4'd5);
    @(negedge clk) drive(0, 1'b1, 4'd5);
    @(negedge clk) drive(0, 1'b0, 4'd0);
    tests++;
    if (st0 !== 3'd3) begin
      fails++;
      $display("FAIL pre_reset st=%0d req 3", st0);
    end
    rstn = 1'b0;
    @(negedge clk);
    tests++;
    if ({st0, nv0, re0, de0, go0} !== 7'd0 ||
        num0 !== 7'd0 || cnt0 !== 7'd0) begin
      fails++;
      $display("FAIL reset_commit st=%0d num=%0d cnt=%0d p=%b",
               st0, num0, cnt0, {nv0, re0, de0});
    end
    rstn = 1'b1;
    sg[0] = 1'b0;
  endtask

  task automatic test_done;
    sg[1] = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      entry(1, 4'(i), 4'd11, 1'b0, K_NV, 7'd0, 7'd0);
      tests++;
      if (nv1 !== 1'b1 || num1 !== 7'(i) || cnt1 !== 7'(i) ||
          st1 !== ((i == 3) ? 3'd4 : 3'd1) ||
          go1 !== (i == 3)) begin
        fails++;
        $display("FAIL max3_%0d nv=%b num=%0d cnt=%0d st=%0d",
                 i, nv1, num1, cnt1, st1);
      end
    end
    entry(1, 4'd2, 4'd11, 1'b0, K_NV, 7'd0, 7'd0);
    tests++;
    if (st1 !== 3'd4 || cnt1 !== 7'd3 ||
        {nv1, re1, de1} !== 3'b000 || go1 !== 1'b1) begin
      fails++;
      $display("FAIL done_ignore st=%0d cnt=%0d p=%b",
               st1, cnt1, {nv1, re1, de1});
    end
    sg[1] = 1'b0;
    @(negedge clk) ng[1] = 1'b1;
    @(negedge clk) ng[1] = 1'b0;
    tests++;
    if (st1 !== 3'd0 || cnt1 !== 7'd0 || go1 !== 1'b0 ||
        num1 !== 7'd0) begin
      fails++;
      $display("FAIL done_new_game st=%0d cnt=%0d go=%b",
               st1, cnt1, go1);
    end
  endtask

  initial begin
    kc[0] = 4'd0;
    kc[1] = 4'd0;
    test_reset();
    test_basic();
    test_range();
    test_dup();
    test_clear();
    test_commit_drop();
    test_start_fall();
    test_new_game();
    test_reset_commit();
    test_done();
    repeat (2) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL missing_results pending=%0d req 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
